endecoder_pipe: RTL and testbench
=================================

Name: endecoder_pipe

Overview:
- Parametrised successor to the 4-bit endecoder core: a multi-round, key-driven encrypt/decrypt engine with a configurable data width, round count and rotation amount.
- Uses valid/ready handshakes on both sides so it can sit behind the chip-top wrapper or inside a streaming datapath.
- Processes one round per clock and holds the result until the consumer accepts it.
- Allows back-to-back operation: a new input is accepted on the same cycle the previous result is taken.

Parameters:
- DATA_W, 4: data and key width in bits; legal range ≥2.
- ROUNDS, 2: number of cipher rounds; legal range ≥1.
- ROT, 1: per-round rotate amount; legal range 1..DATA_W-1.

Ports:
- clk_i  in  1  single system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input word presented.
- in_ready_o  out  1  engine can accept input.
- code_i  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt).
- key_i  in  DATA_W  key; sampled only at acceptance.
- mode_i  in  1  0=encrypt, 1=decrypt; sampled only at acceptance.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer takes the result.
- code_o  out  DATA_W  result word.
- mode_o  out  1  mode the result was computed with.
- busy_o  out  1  high in RUN.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (rst_i sampled on the rising edge of clk_i).
  - Reset values: state=IDLE; in_ready_o=1; out_valid_o=0; code_o=0; mode_o=0; busy_o=0; round counter=0.
- Arithmetic:
  - All arithmetic is modulo 2^DATA_W.
  - Round key: k_r = rotl(key, r mod DATA_W).
  - Encrypt round r, applied for r=0..ROUNDS-1: x <= rotl(x ^ k_r, ROT) + k_r.
  - Decrypt round r, applied for r=ROUNDS-1 down to 0: x <= rotr(x - k_r, ROT) ^ k_r.
  - Decrypt(key, Encrypt(key, p)) == p for every p and key.
- State machine:
  - IDLE:
    - in_ready_o=1.
    - On in_valid_i&&in_ready_o: latch x=code_i, key=key_i, mode=mode_i.
    - Counter = 0 for encrypt, ROUNDS-1 for decrypt; go to RUN.
  - RUN:
    - in_ready_o=0, busy_o=1.
    - Each edge applies one round and steps the counter (+1 for encrypt, -1 for decrypt).
    - After the ROUNDS-th round, go to DONE with code_o=x, mode_o=mode, out_valid_o=1.
  - DONE:
    - out_valid_o=1; code_o and mode_o are held stable while out_ready_i=0.
    - in_ready_o = out_ready_i (combinational).
    - out_ready_i=1 and in_valid_i=1: result retired and the new word latched on the same edge; go to RUN.
    - out_ready_i=1 and in_valid_i=0: go to IDLE; out_valid_o=0; code_o retains its last value.
- Latency:
  - Acceptance on edge E: out_valid_o first high after edge E+ROUNDS.
  - Throughput: one word per ROUNDS+1 cycles with out_ready_i held high.
- Boundary conditions:
  - in_valid_i while RUN: ignored; the source must hold it until in_ready_o=1.
  - Changes on code_i, key_i or mode_i after acceptance: no effect.
  - rst_i during RUN or DONE: the in-flight word is discarded, reset values are forced on the next edge, and no out_valid_o is produced for that word.
  - rst_i has priority over the handshake on the same edge.
  - ROUNDS=1: RUN lasts exactly one cycle.
  - Round index r ≥ DATA_W: rotation wraps (r mod DATA_W).
  - Counter width is max(1, clog2(ROUNDS)); no overflow past ROUNDS-1.

Test Plan:
- Reset then idle (defaults): in_ready_o=1, out_valid_o=0, code_o=0, busy_o=0.
- Encrypt: key_i=0x3, code_i=0x5, mode_i=0 → busy_o high for 2 cycles; out_valid_o after edge E+2 with code_o=0x9, mode_o=0. Intermediate x after round 0 is 0xF.
- Decrypt round-trip: key_i=0x3, code_i=0x9, mode_i=1 → code_o=0x5.
- Exhaustive round-trip: for all 16 keys × 16 plaintexts, decrypt(encrypt(p)) == p.
- Backpressure: hold out_ready_i=0 for 5 cycles → code_o stays 0x9 and in_ready_o=0.
  - Then out_ready_i=1 with in_valid_i=1 (key 0x3, code 0x5, mode 0): next word accepted on the same edge, no IDLE cycle, second result is also 0x9.
- Reset mid-RUN: assert rst_i one cycle after acceptance → next cycle shows IDLE defaults, and no out_valid_o pulse ever appears for that word.

Source files
------------

// File: rtl/endecoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : endecoder_pipe
// Brief    : Multi-round key-driven encrypt/decrypt engine, one round per
//            clock, with valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module endecoder_pipe #(
    parameter int DATA_W = 4,
    parameter int ROUNDS = 2,
    parameter int ROT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] code_i,
    input  logic [DATA_W-1:0] key_i,
    input  logic              mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] code_o,
    output logic              mode_o,
    output logic              busy_o
);

    localparam int                 C_CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [DATA_W-1:0]   r_x_q, w_x_d;
    logic [DATA_W-1:0]   r_key_q, w_key_d;
    logic                r_mode_q, w_mode_d;
    logic [C_CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [DATA_W-1:0]   r_code_q, w_code_d;
    logic                r_mode_out_q, w_mode_out_d;

    logic [31:0]         w_rk_amt;
    logic [DATA_W-1:0]   w_rk;
    logic [DATA_W-1:0]   w_enc;
    logic [DATA_W-1:0]   w_dec;
    logic [DATA_W-1:0]   w_round;
    logic                w_last;
    logic                w_in_ready;
    logic                w_accept;

    // Rotations via a doubled word; valid for amounts 0..DATA_W-1.
    function automatic logic [DATA_W-1:0] f_rotl(input logic [DATA_W-1:0] v,
                                                 input logic [31:0] amt);
        logic [2*DATA_W-1:0] t;
        t = {v, v} << amt;
        return t[2*DATA_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] f_rotr(input logic [DATA_W-1:0] v,
                                                 input logic [31:0] amt);
        logic [2*DATA_W-1:0] t;
        t = {v, v} >> amt;
        return t[DATA_W-1:0];
    endfunction

    always_comb begin
        w_rk_amt = 32'(r_cnt_q) % 32'(DATA_W);
        w_rk     = f_rotl(r_key_q, w_rk_amt);
        w_enc    = f_rotl(r_x_q ^ w_rk, 32'(ROT)) + w_rk;
        w_dec    = f_rotr(r_x_q - w_rk, 32'(ROT)) ^ w_rk;
        w_round  = r_mode_q ? w_dec : w_enc;
        // Decrypt walks the round index downwards, so it finishes at zero.
        w_last   = r_mode_q ? (r_cnt_q == '0) : (r_cnt_q == C_LAST);
    end

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state_q)
            S_IDLE:  w_in_ready = 1'b1;
            S_DONE:  w_in_ready = out_ready_i;
            default: w_in_ready = 1'b0;
        endcase
        w_accept = in_valid_i && w_in_ready;
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_x_d        = r_x_q;
        w_key_d      = r_key_q;
        w_mode_d     = r_mode_q;
        w_cnt_d      = r_cnt_q;
        w_code_d     = r_code_q;
        w_mode_out_d = r_mode_out_q;

        case (r_state_q)
            S_IDLE: ;
            S_RUN: begin
                w_x_d = w_round;
                if (w_last) begin
                    w_state_d    = S_DONE;
                    w_code_d     = w_round;
                    w_mode_out_d = r_mode_q;
                end else begin
                    w_cnt_d = r_mode_q ? (r_cnt_q - C_CNT_W'(1)) : (r_cnt_q + C_CNT_W'(1));
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // Acceptance is only possible in IDLE or DONE and overrides the retire path.
        if (w_accept) begin
            w_state_d = S_RUN;
            w_x_d     = code_i;
            w_key_d   = key_i;
            w_mode_d  = mode_i;
            w_cnt_d   = mode_i ? C_LAST : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q    <= S_IDLE;
            r_x_q        <= '0;
            r_key_q      <= '0;
            r_mode_q     <= 1'b0;
            r_cnt_q      <= '0;
            r_code_q     <= '0;
            r_mode_out_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_x_q        <= w_x_d;
            r_key_q      <= w_key_d;
            r_mode_q     <= w_mode_d;
            r_cnt_q      <= w_cnt_d;
            r_code_q     <= w_code_d;
            r_mode_out_q <= w_mode_out_d;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = (r_state_q == S_DONE);
    assign busy_o      = (r_state_q == S_RUN);
    assign code_o      = r_code_q;
    assign mode_o      = r_mode_out_q;

endmodule
`default_nettype wire

// File: tb/tb_endecoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_endecoder_pipe
// Brief    : Directed, table-driven self-checking bench for endecoder_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_endecoder_pipe;

    localparam int DATA_W = 4;
    localparam int ROUNDS = 2;
    localparam int ROT    = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] code_i;
    logic [DATA_W-1:0] key_i;
    logic              mode_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] code_o;
    logic              mode_o;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    endecoder_pipe #(.DATA_W(DATA_W), .ROUNDS(ROUNDS), .ROT(ROT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .code_i      (code_i),
        .key_i       (key_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .code_o      (code_o),
        .mode_o      (mode_o),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              mode;
        logic [DATA_W-1:0] key;
        logic [DATA_W-1:0] code;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one word, scrambles the inputs while it runs, and retires the result.
    task automatic run_word(input logic m, input logic [DATA_W-1:0] k, input logic [DATA_W-1:0] c,
                            output logic [DATA_W-1:0] res, output logic rm, output int lat);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        mode_i   = m;
        key_i    = k;
        code_i   = c;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        step();
        code_i = ~c;
        key_i  = ~k;
        mode_i = ~m;
        lat    = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        in_valid  = 1'b0;
        res       = code_o;
        rm        = mode_o;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] ct;
        logic [DATA_W-1:0] pt;
        logic              rm;
        int                lat;
        logic              seen;

        vecs[0] = '{1'b0, 4'h3, 4'h5, 4'h9};
        vecs[1] = '{1'b1, 4'h3, 4'h9, 4'h5};
        vecs[2] = '{1'b0, 4'h0, 4'h1, 4'h4};
        vecs[3] = '{1'b1, 4'h0, 4'h4, 4'h1};
        vecs[4] = '{1'b0, 4'hF, 4'h0, 4'h1};
        vecs[5] = '{1'b0, 4'h1, 4'hA, 4'h7};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        code_i    = '0;
        key_i     = '0;
        mode_i    = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_code_o", 32'(code_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mode_o", 32'(mode_o), 32'd0);

        // Basic encrypt with cycle-by-cycle visibility.
        in_valid = 1'b1; key_i = 4'h3; code_i = 4'h5; mode_i = 1'b0;
        step();
        in_valid = 1'b0;
        check("enc_busy_c0", 32'(busy), 32'd1);
        check("enc_in_ready_run", 32'(in_ready), 32'd0);
        check("enc_no_valid_c0", 32'(out_valid), 32'd0);
        step();
        check("enc_busy_c1", 32'(busy), 32'd1);
        check("enc_round0_x", 32'(dut.r_x_q), 32'hF);
        step();
        check("enc_valid_e2", 32'(out_valid), 32'd1);
        check("enc_busy_done", 32'(busy), 32'd0);
        check("enc_code", 32'(code_o), 32'h9);
        check("enc_mode", 32'(mode_o), 32'd0);

        // Backpressure: result held for five cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_code_hold", 32'(code_o), 32'h9);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
        end

        // Back-to-back: retire and accept on the same edge.
        in_valid = 1'b1; key_i = 4'h3; code_i = 4'h5; mode_i = 1'b0; out_ready = 1'b1;
        #1;
        check("b2b_in_ready_comb", 32'(in_ready), 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_busy_no_idle", 32'(busy), 32'd1);
        check("b2b_valid_dropped", 32'(out_valid), 32'd0);
        step();
        step();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_code", 32'(code_o), 32'h9);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("retire_idle_valid", 32'(out_valid), 32'd0);
        check("retire_idle_ready", 32'(in_ready), 32'd1);
        check("retire_code_kept", 32'(code_o), 32'h9);

        // Reset one cycle into RUN discards the word.
        in_valid = 1'b1; key_i = 4'h3; code_i = 4'h5; mode_i = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_code_o", 32'(code_o), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mode_o", 32'(mode_o), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid_pulse", 32'(seen), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].mode, vecs[i].key, vecs[i].code, ct, rm, lat);
            check($sformatf("vec%0d_code", i), 32'(ct), 32'(vecs[i].exp));
            check($sformatf("vec%0d_mode", i), 32'(rm), 32'(vecs[i].mode));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(ROUNDS));
        end

        // Exhaustive round trip over every key and plaintext.
        for (int k = 0; k < 16; k++) begin
            for (int p = 0; p < 16; p++) begin
                run_word(1'b0, 4'(k), 4'(p), ct, rm, lat);
                run_word(1'b1, 4'(k), ct, pt, rm, lat);
                check($sformatf("roundtrip_k%0h_p%0h", k, p), 32'(pt), 32'(p));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
